seq_bit_serializer: RTL and testbench

- Parallel-to-serial stage that sits directly upstream of the 1011 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and drives one bit per clock on out_bit, which feeds the detector's inp_bit.
- The detector samples every cycle, so the serializer always drives a defined bit: data bits while shifting, IDLE_BIT otherwise.
- out_valid qualifies which cycles carry data.

---
 rtl/seq_bit_serializer.sv | 156 +++++++++++++++
 tb/tb_seq_bit_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// ============================================================================
// Module   : seq_bit_serializer
// Purpose  : Parallel-to-serial stage feeding the 1011 sequence detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_bit_serializer #(
   parameter int   WIDTH      = 8,
   parameter bit   LSB_FIRST  = 1'b0,
   parameter int   GAP_CYCLES = 0,
   parameter logic IDLE_BIT   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_bit,
   output logic             out_valid,
   output logic             frame_start,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [4:0] c_BIT_LAST = 5'(WIDTH - 1);
   localparam bit         c_HAS_GAP  = (GAP_CYCLES > 0);
   localparam logic [3:0] c_GAP_LAST = c_HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [4:0]         bit_cnt_q, bit_cnt_d;
   logic [3:0]         gap_cnt_q, gap_cnt_d;
   logic               out_bit_q, out_bit_d;
   logic               out_valid_q, out_valid_d;
   logic               frame_start_q, frame_start_d;

   logic               w_ready;
   logic               w_accept;
   logic [WIDTH-1:0]   w_rotated;
   logic               w_head_in;
   logic               w_head_rot;

   // The shift register rotates so every bit stays live; the head bit is what
   // goes out on the next cycle.
   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign w_rotated  = {shreg_q[0], shreg_q[WIDTH-1:1]};
         assign w_head_in  = in_data[0];
         assign w_head_rot = shreg_q[1];
      end else begin : g_msb_first
         assign w_rotated  = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
         assign w_head_in  = in_data[WIDTH-1];
         assign w_head_rot = shreg_q[WIDTH-2];
      end
   endgenerate

   always_comb begin
      w_ready = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_IDLE:  w_ready = 1'b1;
            ST_SHIFT: w_ready = (bit_cnt_q == c_BIT_LAST) && !c_HAS_GAP;
            ST_GAP:   w_ready = (gap_cnt_q == c_GAP_LAST);
            default:  w_ready = 1'b0;
         endcase
      end
   end

   assign w_accept = in_valid & w_ready;

   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      bit_cnt_d     = bit_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      out_bit_d     = IDLE_BIT;
      out_valid_d   = 1'b0;
      frame_start_d = 1'b0;

      case (state_q)
         ST_SHIFT: begin
            if (bit_cnt_q != c_BIT_LAST) begin
               shreg_d     = w_rotated;
               bit_cnt_d   = bit_cnt_q + 5'd1;
               out_bit_d   = w_head_rot;
               out_valid_d = 1'b1;
            end else if (c_HAS_GAP) begin
               state_d   = ST_GAP;
               bit_cnt_d = 5'd0;
               gap_cnt_d = 4'd0;
            end else if (!w_accept) begin
               state_d   = ST_IDLE;
               bit_cnt_d = 5'd0;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == c_GAP_LAST) begin
               if (!w_accept) begin
                  state_d   = ST_IDLE;
                  gap_cnt_d = 4'd0;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Accept is only possible where w_ready allows it, so a load here never
      // cuts short a word that is still shifting.
      if (w_accept) begin
         state_d       = ST_SHIFT;
         shreg_d       = in_data;
         bit_cnt_d     = 5'd0;
         gap_cnt_d     = 4'd0;
         out_bit_d     = w_head_in;
         out_valid_d   = 1'b1;
         frame_start_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         shreg_q       <= '0;
         bit_cnt_q     <= 5'd0;
         gap_cnt_q     <= 4'd0;
         out_bit_q     <= IDLE_BIT;
         out_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         out_bit_q     <= out_bit_d;
         out_valid_q   <= out_valid_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign in_ready    = w_ready;
   assign out_bit     = out_bit_q;
   assign out_valid   = out_valid_q;
   assign frame_start = frame_start_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
// ============================================================================
// Module   : tb_seq_bit_serializer
// Purpose  : Directed self-checking bench for seq_bit_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_bit_serializer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din = 8'h00;
   logic       iv  [3];
   logic       rdy [3];
   logic       ob  [3];
   logic       ov  [3];
   logic       fs  [3];
   logic       bsy [3];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // u_dut: MSB first, no gap; u_gap: three gap cycles; u_lsb: LSB first.
   seq_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) u_dut (
      .clk(clk), .reset(reset), .in_data(din), .in_valid(iv[0]), .in_ready(rdy[0]),
      .out_bit(ob[0]), .out_valid(ov[0]), .frame_start(fs[0]), .busy(bsy[0]));

   seq_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(3), .IDLE_BIT(1'b0)) u_gap (
      .clk(clk), .reset(reset), .in_data(din), .in_valid(iv[1]), .in_ready(rdy[1]),
      .out_bit(ob[1]), .out_valid(ov[1]), .frame_start(fs[1]), .busy(bsy[1]));

   seq_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .in_data(din), .in_valid(iv[2]), .in_ready(rdy[2]),
      .out_bit(ob[2]), .out_valid(ov[2]), .frame_start(fs[2]), .busy(bsy[2]));

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input int u, input string tag, input logic e_ob, input logic e_ov,
                            input logic e_fs, input logic e_rdy, input logic e_bsy);
      chk({tag, " out_bit"},     ob[u],  e_ob);
      chk({tag, " out_valid"},   ov[u],  e_ov);
      chk({tag, " frame_start"}, fs[u],  e_fs);
      chk({tag, " in_ready"},    rdy[u], e_rdy);
      chk({tag, " busy"},        bsy[u], e_bsy);
   endtask

   initial begin
      logic [7:0]  w8;
      logic [15:0] s16;
      logic        e_data;

      iv[0] = 1'b0;
      iv[1] = 1'b0;
      iv[2] = 1'b0;

      // Reset held: everything idle and in_ready gated low.
      repeat (2) @(negedge clk);
      for (int u = 0; u < 3; u++) chk_state(u, $sformatf("rst u%0d", u), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      for (int u = 0; u < 3; u++) chk_state(u, $sformatf("rel u%0d", u), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Single word 0xB0, MSB first.
      w8 = 8'hB0;
      din = w8;
      iv[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk_state(0, $sformatf("t1 c%0d", k), w8[8-k], 1'b1, k == 1, k == 8, 1'b1);
         iv[0] = 1'b0;
      end
      @(negedge clk);
      chk_state(0, "t1 idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Back-to-back 0x0B then 0xB0 with in_valid held.
      s16 = 16'h0BB0;
      din = 8'h0B;
      iv[0] = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk_state(0, $sformatf("t2 c%0d", k), s16[16-k], 1'b1, (k == 1) || (k == 9),
                   (k == 8) || (k == 16), 1'b1);
         if (k == 1) din = 8'hB0;
         if (k == 9) iv[0] = 1'b0;
      end
      @(negedge clk);
      chk_state(0, "t2 idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // in_valid toggling and in_data churn while shifting 0x3C; next word 0x81.
      s16 = 16'h3C81;
      din = 8'h3C;
      iv[0] = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk_state(0, $sformatf("t6 c%0d", k), s16[16-k], 1'b1, (k == 1) || (k == 9),
                   (k == 8) || (k == 16), 1'b1);
         if (k < 8) begin
            iv[0] = k[0];
            din   = 8'(k * 37);
         end else if (k == 8) begin
            iv[0] = 1'b1;
            din   = 8'h81;
         end else begin
            iv[0] = 1'b0;
         end
      end
      @(negedge clk);
      chk_state(0, "t6 idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Three-cycle gap between two 0xFF words.
      din = 8'hFF;
      iv[1] = 1'b1;
      for (int k = 1; k <= 23; k++) begin
         @(negedge clk);
         e_data = (k <= 8) || ((k >= 12) && (k <= 19));
         chk_state(1, $sformatf("t3 c%0d", k), e_data, e_data, (k == 1) || (k == 12),
                   (k == 11) || (k == 22) || (k == 23), k <= 22);
         if (k == 12) iv[1] = 1'b0;
      end

      // LSB first, 0x0D gives 1,0,1,1,0,0,0,0.
      w8 = 8'h0D;
      din = w8;
      iv[2] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk_state(2, $sformatf("t4 c%0d", k), w8[k-1], 1'b1, k == 1, k == 8, 1'b1);
         iv[2] = 1'b0;
      end
      @(negedge clk);
      chk_state(2, "t4 idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset after bit 3 of 0xAA, then 0x55 in full.
      w8 = 8'hAA;
      din = w8;
      iv[0] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk_state(0, $sformatf("t5a c%0d", k), w8[8-k], 1'b1, k == 1, 1'b0, 1'b1);
         iv[0] = 1'b0;
      end
      #2;
      reset = 1'b1;
      #1;
      chk_state(0, "t5 async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk_state(0, "t5 held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      chk_state(0, "t5 rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      w8 = 8'h55;
      din = w8;
      iv[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk_state(0, $sformatf("t5b c%0d", k), w8[8-k], 1'b1, k == 1, k == 8, 1'b1);
         iv[0] = 1'b0;
      end
      @(negedge clk);
      chk_state(0, "t5 idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
